// File: rtl/game_pkg.sv
// Shared game constants, screen codes, BCD converter state type and digit adjust helper.
// No ports; imported by score_keeper and bin2bcd_seq.
package game_pkg;

    localparam int unsigned SCORE_W           = 20;
    localparam int unsigned BCD_DIGITS        = 6;
    localparam int unsigned BCD_W             = 4 * BCD_DIGITS;
    localparam int unsigned SCROLL_W          = 10;
    localparam int unsigned SHOW_W            = 3;
    localparam int unsigned BCD_CNT_W         = 5;
    localparam int unsigned SCORE_MAX_DEFAULT = 999999;

    localparam logic [SHOW_W-1:0] SHOW_PLAY  = 3'd0;
    localparam logic [SHOW_W-1:0] SHOW_START = 3'd1;
    localparam logic [SHOW_W-1:0] SHOW_DEAD  = 3'd3;

    typedef enum logic [1:0] {
        BCD_IDLE,
        BCD_LOAD,
        BCD_SHIFT,
        BCD_DONE
    } bcd_state_e;

    // Shift-add-3 correction: every digit >= 5 gets +3 before the next left shift.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                res[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), IDLE -> LOAD -> SHIFT x20 -> DONE -> IDLE.
// Ports:
//   Clk, Reset    : clock, synchronous active-high reset (aborts a running conversion)
//   start         : request a conversion; honoured only in IDLE
//   bin[19:0]     : value to convert, captured during LOAD
//   busy          : high in LOAD and SHIFT
//   done          : high in DONE, the cycle whose closing edge writes bcd
//   bcd[23:0]     : last completed result, six BCD digits, digit 0 in [3:0]
module bin2bcd_seq
    import game_pkg::*;
(
    input  logic               Clk,
    input  logic               Reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_W-1:0]   bcd
);

    localparam int unsigned SH_W       = BCD_W + SCORE_W;
    localparam int unsigned LAST_SHIFT = SCORE_W - 1;

    bcd_state_e           state;
    logic [SCORE_W-1:0]   bin_q;
    logic [BCD_W-1:0]     acc;
    logic [BCD_W-1:0]     acc_adj;
    logic [BCD_CNT_W-1:0] cnt;
    logic [SH_W-1:0]      shifted;

    // One double-dabble step: correct digits, then shift the {digits, binary} pair left.
    assign acc_adj = bcd_add3(acc);
    assign shifted = {acc_adj, bin_q} << 1;

    // Converter FSM; bcd is only written in DONE so partial results never show.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= BCD_IDLE;
            bin_q <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
        end else begin
            case (state)
                BCD_IDLE: begin
                    if (start) begin
                        state <= BCD_LOAD;
                        busy  <= 1'b1;
                    end
                end
                BCD_LOAD: begin
                    bin_q <= bin;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= BCD_SHIFT;
                end
                BCD_SHIFT: begin
                    acc   <= shifted[SH_W-1:SCORE_W];
                    bin_q <= shifted[SCORE_W-1:0];
                    cnt   <= cnt + BCD_CNT_W'(1);
                    if (cnt == BCD_CNT_W'(LAST_SHIFT)) begin
                        state <= BCD_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                BCD_DONE: begin
                    bcd   <= acc;
                    done  <= 1'b0;
                    state <= BCD_IDLE;
                end
                default: begin
                    state <= BCD_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: accumulates scroll distance per frame, tracks the high score and
// keeps a BCD copy of the score for the display.
// Ports:
//   Clk, Reset          : clock, synchronous active-high reset
//   frame_clk           : raw frame-rate clock, sampled and edge-detected in the Clk domain
//   restart             : high while the controller is on the start screen; clears score
//   show[2:0]           : screen code (0 play, 1 start, 3 dead)
//   scroll_px[9:0]      : pixels scrolled this frame, added on each frame tick while playing
//   score, high_score   : current and best score, saturating at SCORE_MAX
//   score_bcd[23:0]     : BCD of the score, updated only by completed conversions
//   bcd_valid           : score_bcd matches the current score
//   new_record          : set by a record-setting death, cleared when restart rises
module score_keeper
    import game_pkg::*;
#(
    parameter int unsigned SCORE_MAX = SCORE_MAX_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic                restart,
    input  logic [SHOW_W-1:0]   show,
    input  logic [SCROLL_W-1:0] scroll_px,
    output logic [SCORE_W-1:0]  score,
    output logic [SCORE_W-1:0]  high_score,
    output logic [BCD_W-1:0]    score_bcd,
    output logic                bcd_valid,
    output logic                new_record
);

    localparam int unsigned       SUM_W   = SCORE_W + 1;
    localparam logic [SUM_W-1:0]  MAX_EXT = SUM_W'(SCORE_MAX);

    logic               frame_q;
    logic               frame_q2;
    logic               frame_tick;
    logic [SHOW_W-1:0]  show_q;
    logic               restart_q;
    logic               load_q;
    logic [SCORE_W-1:0] snapshot;
    logic               conv_busy;
    logic               conv_done;

    logic [SUM_W-1:0]   sum_c;
    logic [SCORE_W-1:0] sat_c;
    logic               dead_entry_c;
    logic               restart_rise_c;
    logic               conv_idle_c;
    logic               start_c;

    // Saturating accumulate keeps the score inside six BCD digits.
    always_comb begin
        sum_c = SUM_W'(score) + SUM_W'(scroll_px);
        sat_c = (sum_c > MAX_EXT) ? SCORE_W'(SCORE_MAX) : sum_c[SCORE_W-1:0];
    end

    assign dead_entry_c   = (show == SHOW_DEAD) && (show_q != SHOW_DEAD);
    assign restart_rise_c = restart && !restart_q;

    // Converter is idle only when neither working nor writing its result.
    assign conv_idle_c = !(conv_busy || conv_done);
    assign start_c     = conv_idle_c && (snapshot != score);
    assign bcd_valid   = conv_idle_c && (snapshot == score);

    // Frame edge detect, score/high-score update and conversion snapshot.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_q    <= 1'b0;
            frame_q2   <= 1'b0;
            frame_tick <= 1'b0;
            show_q     <= '0;
            restart_q  <= 1'b0;
            load_q     <= 1'b0;
            snapshot   <= '0;
            score      <= '0;
            high_score <= '0;
            new_record <= 1'b0;
        end else begin
            frame_q    <= frame_clk;
            frame_q2   <= frame_q;
            frame_tick <= frame_q && !frame_q2;
            show_q     <= show;
            restart_q  <= restart;
            // load_q mirrors the converter's LOAD cycle, so both capture the same score.
            load_q     <= start_c;
            if (load_q) begin
                snapshot <= score;
            end

            if (restart) begin
                score <= '0;
            end else if (frame_tick && (show == SHOW_PLAY)) begin
                score <= sat_c;
            end

            if (dead_entry_c && (score > high_score)) begin
                high_score <= score;
                new_record <= 1'b1;
            end
            if (restart_rise_c) begin
                new_record <= 1'b0;
            end
        end
    end

    bin2bcd_seq u_bin2bcd (
        .Clk   (Clk),
        .Reset (Reset),
        .start (start_c),
        .bin   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (score_bcd)
    );

endmodule
